// File: rtl/image_downsample_2x.sv
// 2x image downsampler: reads 2x2 source blocks (or just the top-left pixel) from an
// external memory with fixed read latency and writes one output pixel per block in raster order.
module image_downsample_2x #(
  parameter int BIT_DEPTH    = 8,
  parameter int OLD_WIDTH    = 64,
  parameter int OLD_HEIGHT   = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                                             clk_in,
  input  logic                                             rst_in,
  input  logic                                             start_in,
  input  logic                                             mode_in,
  output logic [$clog2(OLD_WIDTH*OLD_HEIGHT)-1:0]          ext_read_addr,
  output logic                                             ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]                             ext_pixel_in,
  output logic [$clog2(OLD_WIDTH/2*OLD_HEIGHT/2)-1:0]      ext_write_addr,
  output logic                                             ext_write_valid,
  output logic [BIT_DEPTH-1:0]                             ext_pixel_out,
  output logic                                             busy_out,
  output logic                                             resize_done
);

  localparam int RA = $clog2(OLD_WIDTH*OLD_HEIGHT);
  localparam int WA = $clog2(OLD_WIDTH/2*OLD_HEIGHT/2);
  localparam int SW = BIT_DEPTH + 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic                      mode_r;
  logic [RA-1:0]             x_r;
  logic [RA-1:0]             y_r;
  logic [1:0]                phase_r;
  logic [15:0]               wait_cnt_r;
  logic [READ_LATENCY-1:0]   vpipe_r;
  logic [SW-1:0]             sum_r;

  logic                      last_read_s;
  logic                      wait_done_s;
  logic                      last_x_s;
  logic                      last_y_s;
  logic [RA-1:0]             nx_s;
  logic [RA-1:0]             ny_s;
  logic                      capture_s;
  logic [SW-1:0]             sum_next_s;
  logic [SW-1:0]             rounded_s;
  logic [BIT_DEPTH-1:0]      result_s;

  // Source address of one of the four taps of the 2x2 block belonging to output (cx, cy).
  function automatic logic [RA-1:0] src_addr(input logic [RA-1:0] cx,
                                             input logic [RA-1:0] cy,
                                             input logic [1:0]    ph);
    logic [RA-1:0] base;
    base = (cy * RA'(2*OLD_WIDTH)) + (cx << 1);
    case (ph)
      2'd0:    src_addr = base;
      2'd1:    src_addr = base + RA'(1);
      2'd2:    src_addr = base + RA'(OLD_WIDTH);
      2'd3:    src_addr = base + RA'(OLD_WIDTH + 1);
      default: src_addr = base;
    endcase
  endfunction

  // Datapath decode: sequencing flags, next coordinates and the pixel about to be written.
  always_comb begin
    last_read_s = mode_r ? (phase_r == 2'd3) : 1'b1;
    wait_done_s = (wait_cnt_r == 16'(READ_LATENCY - 1));
    last_x_s    = (x_r == RA'(OLD_WIDTH/2 - 1));
    last_y_s    = (y_r == RA'(OLD_HEIGHT/2 - 1));
    if (last_x_s) begin
      nx_s = {RA{1'b0}};
      ny_s = y_r + RA'(1);
    end else begin
      nx_s = x_r + RA'(1);
      ny_s = y_r;
    end
    // A sample lands exactly READ_LATENCY cycles after its address was issued.
    capture_s  = vpipe_r[READ_LATENCY-1];
    sum_next_s = sum_r + (capture_s ? {2'b00, ext_pixel_in} : {SW{1'b0}});
    rounded_s  = sum_next_s + SW'(2);
    if (mode_r) begin
      result_s = BIT_DEPTH'(rounded_s >> 2);
    end else begin
      result_s = BIT_DEPTH'(sum_next_s);
    end
  end

  // Next-state logic of the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (start_in) state_s = S_READ; else state_s = S_IDLE;
      S_READ:  if (last_read_s) state_s = S_WAIT; else state_s = S_READ;
      S_WAIT:  if (wait_done_s) state_s = S_WRITE; else state_s = S_WAIT;
      S_WRITE: if (last_x_s && last_y_s) state_s = S_DONE; else state_s = S_READ;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs; reset also flushes reads still in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_r              <= 1'b0;
      x_r                 <= {RA{1'b0}};
      y_r                 <= {RA{1'b0}};
      phase_r             <= 2'd0;
      wait_cnt_r          <= 16'd0;
      vpipe_r             <= {READ_LATENCY{1'b0}};
      sum_r               <= {SW{1'b0}};
      ext_read_addr       <= {RA{1'b0}};
      ext_read_addr_valid <= 1'b0;
      ext_write_addr      <= {WA{1'b0}};
      ext_write_valid     <= 1'b0;
      ext_pixel_out       <= {BIT_DEPTH{1'b0}};
      busy_out            <= 1'b0;
      resize_done         <= 1'b0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        vpipe_r[i] <= vpipe_r[i-1];
      end
      vpipe_r[0] <= ext_read_addr_valid;
      case (state_r)
        S_IDLE: begin
          if (start_in) begin
            mode_r              <= mode_in;
            x_r                 <= {RA{1'b0}};
            y_r                 <= {RA{1'b0}};
            phase_r             <= 2'd0;
            sum_r               <= {SW{1'b0}};
            busy_out            <= 1'b1;
            ext_read_addr_valid <= 1'b1;
            ext_read_addr       <= src_addr({RA{1'b0}}, {RA{1'b0}}, 2'd0);
          end
        end
        S_READ: begin
          sum_r <= sum_next_s;
          if (last_read_s) begin
            ext_read_addr_valid <= 1'b0;
            wait_cnt_r          <= 16'd0;
          end else begin
            phase_r       <= phase_r + 2'd1;
            ext_read_addr <= src_addr(x_r, y_r, phase_r + 2'd1);
          end
        end
        S_WAIT: begin
          sum_r      <= sum_next_s;
          wait_cnt_r <= wait_cnt_r + 16'd1;
          // Present the result during the WRITE cycle itself, folding in the final sample.
          if (wait_done_s) begin
            ext_write_valid <= 1'b1;
            ext_write_addr  <= WA'(y_r * RA'(OLD_WIDTH/2) + x_r);
            ext_pixel_out   <= result_s;
          end
        end
        S_WRITE: begin
          ext_write_valid <= 1'b0;
          sum_r           <= {SW{1'b0}};
          x_r             <= nx_s;
          y_r             <= ny_s;
          phase_r         <= 2'd0;
          if (last_x_s && last_y_s) begin
            busy_out    <= 1'b0;
            resize_done <= 1'b1;
          end else begin
            ext_read_addr_valid <= 1'b1;
            ext_read_addr       <= src_addr(nx_s, ny_s, 2'd0);
          end
        end
        S_DONE: begin
          resize_done <= 1'b0;
        end
        default: begin
          resize_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_downsample_2x.sv
// Self-checking bench for image_downsample_2x on a 4x4 image with a latency-2 memory model.
module tb_image_downsample_2x;
  localparam int BD = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int L  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] rd_addr;
  logic       rd_valid;
  logic [7:0] pix_in;
  logic [1:0] wr_addr;
  logic       wr_valid;
  logic [7:0] pix_out;
  logic       busy;
  logic       done;

  image_downsample_2x #(.BIT_DEPTH(BD), .OLD_WIDTH(W), .OLD_HEIGHT(H), .READ_LATENCY(L)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .mode_in(mode),
    .ext_read_addr(rd_addr), .ext_read_addr_valid(rd_valid), .ext_pixel_in(pix_in),
    .ext_write_addr(wr_addr), .ext_write_valid(wr_valid), .ext_pixel_out(pix_out),
    .busy_out(busy), .resize_done(done)
  );

  always #5 clk = ~clk;

  // Memory model: data for an address appears L cycles after it is presented.
  logic [7:0] mem [16];
  logic [7:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= mem[rd_addr];
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign pix_in = pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wa_q[$];
  int wd_q[$];
  int wc_q[$];
  int wb_q[$];
  int ra_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int done_busy = 0;

  // Observe DUT outputs mid-cycle.
  always @(negedge clk) begin
    if (wr_valid) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(int'(pix_out));
      wc_q.push_back(cyc);
      wb_q.push_back(int'(busy));
    end
    if (rd_valid) ra_q.push_back(int'(rd_addr));
    if (done) begin
      done_cnt  = done_cnt + 1;
      done_cyc  = cyc;
      done_busy = int'(busy);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_pixel(input int m, input int k);
    int ox, oy, b;
    ox = k % (W/2);
    oy = k / (W/2);
    b  = 2*oy*W + 2*ox;
    if (m == 0) return int'(mem[b]);
    return (int'(mem[b]) + int'(mem[b+1]) + int'(mem[b+W]) + int'(mem[b+W+1]) + 2) / 4;
  endfunction

  task automatic clear_obs();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); wb_q.delete(); ra_q.delete();
    done_cnt = 0;
    done_cyc = 0;
    done_busy = 0;
  endtask

  task automatic run_frame(input string tag, input int m, input bit disturb);
    int n, scyc, ridx;
    n = (m == 1) ? 4 : 1;
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; mode = m[0]; scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (disturb) begin
      repeat (5) @(posedge clk);
      #1 start = 1'b1; mode = ~mode;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 mode = ~mode;
    end
    for (int i = 0; i < 300 && done_cnt == 0; i++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_wr_cnt"}, wa_q.size(), 4);
    chk({tag, "_rd_cnt"}, ra_q.size(), 4*n);
    if (wa_q.size() == 4) begin
      chk({tag, "_first_wr_cyc"}, wc_q[0], scyc + 1 + n + L);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s_waddr%0d", tag, k), wa_q[k], k);
        chk($sformatf("%s_wdata%0d", tag, k), wd_q[k], exp_pixel(m, k));
        chk($sformatf("%s_wbusy%0d", tag, k), wb_q[k], 1);
        if (k > 0) chk($sformatf("%s_period%0d", tag, k), wc_q[k] - wc_q[k-1], n + L + 1);
      end
      chk({tag, "_done_after_last"}, done_cyc, wc_q[3] + 1);
    end
    chk({tag, "_busy_at_done"}, done_busy, 0);
    ridx = 0;
    for (int k = 0; k < 4 && ra_q.size() == 4*n; k++) begin
      int b;
      b = 2*(k/2)*W + 2*(k%2);
      chk($sformatf("%s_raddr%0d", tag, ridx), ra_q[ridx], b); ridx++;
      if (n == 4) begin
        chk($sformatf("%s_raddr%0d", tag, ridx), ra_q[ridx], b+1);   ridx++;
        chk($sformatf("%s_raddr%0d", tag, ridx), ra_q[ridx], b+W);   ridx++;
        chk($sformatf("%s_raddr%0d", tag, ridx), ra_q[ridx], b+W+1); ridx++;
      end
    end
    chk({tag, "_hold_addr"}, int'(wr_addr), 3);
    chk({tag, "_hold_data"}, int'(pix_out), exp_pixel(m, 3));
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int nw, nd;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({rd_addr, rd_valid, wr_addr, wr_valid, pix_out, busy, done}), 0);
    rst = 1'b0;

    run_frame("ramp_dec", 0, 1'b0);
    run_frame("ramp_avg", 1, 1'b0);

    for (int i = 0; i < 16; i++) mem[i] = 8'd255;
    run_frame("sat_avg", 1, 1'b0);

    fill_random();
    mem[0] = 8'd1; mem[1] = 8'd1; mem[4] = 8'd1; mem[5] = 8'd2;
    run_frame("round_avg", 1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_frame($sformatf("rnd_dec%0d", r), 0, 1'b0);
      run_frame($sformatf("rnd_avg%0d", r), 1, 1'b0);
    end

    fill_random();
    run_frame("disturb_avg", 1, 1'b1);
    run_frame("disturb_dec", 0, 1'b1);

    // Reset in the middle of a frame: outputs clear, nothing further is written.
    fill_random();
    clear_obs();
    @(posedge clk); #1 start = 1'b1; mode = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 100 && wa_q.size() < 2; i++) @(posedge clk);
    chk("rst_two_writes_seen", wa_q.size(), 2);
    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_outputs_zero", int'({rd_addr, rd_valid, wr_addr, wr_valid, pix_out, busy, done}), 0);
    nw = wa_q.size();
    nd = done_cnt;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_more_writes", wa_q.size(), nw);
    chk("rst_no_done", done_cnt, nd);
    chk("rst_start_ignored", int'(busy), 0);
    run_frame("after_rst_avg", 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
